mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: maximum consecutive data grants while a fetch is pending.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port if_req, input, 1: instruction fetch request, held until granted.
REQ-005 SHALL have port if_addr, input, 32: fetch byte address (PC).
REQ-006 SHALL have port if_gnt, output, 1: fetch granted this cycle.
REQ-007 SHALL have port if_valid, output, 1: fetch data valid, one-cycle pulse.
REQ-008 SHALL have port if_rdata, output, 32: fetched instruction, held between pulses.
REQ-009 SHALL have ports dm_ren and dm_wen, input, 1 each: data read/write request, held until granted; never both high.
REQ-010 SHALL have ports dm_addr and dm_wdata, input, 32 each: data address and store data.
REQ-011 SHALL have ports dm_gnt and dm_valid, output, 1 each: data grant; read data valid, one-cycle pulse.
REQ-012 SHALL have port dm_rdata, output, 32: load data, held between pulses.
REQ-013 SHALL have port stall, output, 1: pipeline freeze, high when any request is pending and not granted.
REQ-014 SHALL have ports mem_en (1), mem_we (4), mem_addr (32), mem_wdata (32), output, and mem_rdata (32), input: single-port synchronous memory with 1-cycle read latency.

Function
REQ-015 SHALL grant at most one access per cycle; if_gnt, dm_gnt, mem_* are combinational from requests and state.
REQ-016 SHALL give data requests priority over fetch, except when the starvation counter equals STARVE_LIMIT and if_req is high, in which case fetch SHALL be granted.
REQ-017 SHALL increment the starvation counter on each data grant while if_req is high, saturating at STARVE_LIMIT; clear it on any fetch grant or when if_req is low.
REQ-018 SHALL drive mem_en=1, mem_addr from the granted port, mem_we=4'b1111 only for a data write grant, else 4'b0000.
REQ-019 SHALL track the outstanding read in a state register: IDLE, IF_RD, DM_RD; the next state is IF_RD on fetch grant, DM_RD on data-read grant, IDLE otherwise (including a write grant).
REQ-020 SHALL, in IF_RD, assert if_valid and register mem_rdata into if_rdata; in DM_RD, assert dm_valid and register it into dm_rdata.
REQ-021 SHALL allow back-to-back grants: a new grant may issue in the same cycle a previous read's data returns.
REQ-022 SHALL produce no dm_valid for writes; a write completes in its grant cycle.
REQ-023 SHALL drive stall = (if_req & ~if_gnt) | ((dm_ren|dm_wen) & ~dm_gnt).
REQ-024 SHALL treat dm_ren and dm_wen both high as a read and ignore dm_wen.

Reset
REQ-025 SHALL, while rst is high, force state IDLE, the starvation counter to 0, and if_valid, dm_valid, if_rdata and dm_rdata to 0.
REQ-026 SHALL discard a read that is outstanding when rst asserts; no valid pulse follows reset release.
REQ-027 SHALL suppress all grants and mem_en while rst is high.

Structure
REQ-028 SHALL place the state encoding (IDLE, IF_RD, DM_RD) and the STARVE_LIMIT default in the shared CPU package.
REQ-029 SHALL be a single module with no sub-modules; the counter and FSM are inline.

Verification
REQ-030 SHALL check fetch only: if_req=1, if_addr=0x0 with mem[0]=0x20020005 -> if_gnt same cycle, if_valid next cycle, if_rdata=0x20020005.
REQ-031 SHALL check collision: if_req and dm_wen high together with dm_addr=84, dm_wdata=7 -> dm_gnt, mem_we=4'hF, stall=1 that cycle; fetch granted the next cycle.
REQ-032 SHALL check load-after-store: write 7 to address 84, then dm_ren at 84 -> dm_valid one cycle after grant, dm_rdata=7.
REQ-033 SHALL check starvation: dm_ren high continuously with if_req high -> fetch granted on the 5th cycle after 4 data grants; the counter then clears.
REQ-034 SHALL check back-to-back fetches at addresses 0, 4, 8 -> three consecutive if_valid pulses with matching data and no stall.
REQ-035 SHALL check reset mid-read: assert rst the cycle after a data-read grant -> no dm_valid, all outputs 0, IDLE after release.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared CPU definitions for the memory arbiter: outstanding-read state
// encoding and the default fetch starvation limit.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IF_RD = 2'd1,
    DM_RD = 2'd2
  } arb_state_e;

  localparam int unsigned STARVE_LIMIT_DEF = 4;

endpackage : mem_arbiter_pkg

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Data has priority; a saturating counter forces a fetch grant after STARVE_LIMIT data grants.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  input  logic        dm_ren,
  input  logic        dm_wen,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_valid,
  output logic [31:0] dm_rdata,
  output logic        stall,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  arb_state_e  state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic [31:0] if_rdata_q;
  logic [31:0] dm_rdata_q;

  logic data_req;
  logic fetch_force;

  assign data_req    = dm_ren | dm_wen;
  assign fetch_force = if_req && (starve_q == CW'(STARVE_LIMIT));

  always_comb begin
    dm_gnt    = !rst && data_req && !fetch_force;
    if_gnt    = !rst && if_req && !dm_gnt;
    mem_en    = if_gnt | dm_gnt;
    mem_addr  = dm_gnt ? dm_addr : if_addr;
    mem_wdata = dm_wdata;
    // A read wins when both strobes are high, so the write enable needs ~dm_ren.
    mem_we    = (dm_gnt && dm_wen && !dm_ren) ? 4'b1111 : 4'b0000;
    stall     = (if_req & ~if_gnt) | (data_req & ~dm_gnt);
  end

  always_comb begin
    state_d = IDLE;
    if (if_gnt)
      state_d = IF_RD;
    else if (dm_gnt && dm_ren)
      state_d = DM_RD;

    starve_d = starve_q;
    if (if_gnt || !if_req)
      starve_d = '0;
    else if (dm_gnt && (starve_q != CW'(STARVE_LIMIT)))
      starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      starve_q   <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      if (state_q == IF_RD)
        if_rdata_q <= mem_rdata;
      if (state_q == DM_RD)
        dm_rdata_q <= mem_rdata;
    end
  end

  // The valid cycle forwards the memory word directly; the hold register
  // keeps it visible between pulses without adding a cycle of latency.
  assign if_valid = (state_q == IF_RD);
  assign dm_valid = (state_q == DM_RD);
  assign if_rdata = if_valid ? mem_rdata : if_rdata_q;
  assign dm_rdata = dm_valid ? mem_rdata : dm_rdata_q;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: grants are checked inline, returned read
// data is checked by a monitor against queued expectations.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        dm_ren;
  logic        dm_wen;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_valid;
  logic [31:0] dm_rdata;
  logic        stall;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:255];
  logic [31:0] exp_if[$];
  logic [31:0] exp_dm[$];
  int unsigned errors = 0;
  int unsigned checks = 0;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_gnt   (if_gnt),
    .if_valid (if_valid),
    .if_rdata (if_rdata),
    .dm_ren   (dm_ren),
    .dm_wen   (dm_wen),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_gnt   (dm_gnt),
    .dm_valid (dm_valid),
    .dm_rdata (dm_rdata),
    .stall    (stall),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we == 4'hF)
        mem[mem_addr[9:2]] <= mem_wdata;
      mem_rdata <= mem[mem_addr[9:2]];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (if_valid === 1'b1) begin
      if (exp_if.size() == 0)
        check("unexpected if_valid", 32'(if_valid), 32'd0);
      else
        check("if_rdata", if_rdata, exp_if.pop_front());
    end
    if (dm_valid === 1'b1) begin
      if (exp_dm.size() == 0)
        check("unexpected dm_valid", 32'(dm_valid), 32'd0);
      else
        check("dm_rdata", dm_rdata, exp_dm.pop_front());
    end
  end

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic dw, input logic [31:0] da, input logic [31:0] dd);
    if_req   = ir;
    if_addr  = ia;
    dm_ren   = dr;
    dm_wen   = dw;
    dm_addr  = da;
    dm_wdata = dd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0] = 32'h2002_0005;
    mem[1] = 32'h0040_0093;
    mem[2] = 32'h0010_8113;
    mem[3] = 32'h0000_006F;
    mem_rdata = 32'h0;
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset state
    @(negedge clk);
    check("rst if_valid", 32'(if_valid), 32'd0);
    check("rst dm_valid", 32'(dm_valid), 32'd0);
    check("rst if_rdata", if_rdata, 32'h0);
    check("rst dm_rdata", dm_rdata, 32'h0);
    check("rst mem_en", 32'(mem_en), 32'd0);
    next_cycle();
    rst = 1'b0;

    // Single fetch
    drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("f1 if_gnt", 32'(if_gnt), 32'd1);
    check("f1 mem_en", 32'(mem_en), 32'd1);
    check("f1 mem_we", 32'(mem_we), 32'd0);
    check("f1 stall", 32'(stall), 32'd0);
    exp_if.push_back(32'h2002_0005);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("f1 if_valid", 32'(if_valid), 32'd1);
    next_cycle();
    @(negedge clk);
    check("f1 hold if_valid", 32'(if_valid), 32'd0);
    check("f1 hold if_rdata", if_rdata, 32'h2002_0005);

    // Collision: write wins, fetch follows
    next_cycle();
    drive(1'b1, 32'h4, 1'b0, 1'b1, 32'd84, 32'd7);
    @(negedge clk);
    check("col dm_gnt", 32'(dm_gnt), 32'd1);
    check("col if_gnt", 32'(if_gnt), 32'd0);
    check("col mem_we", 32'(mem_we), 32'hF);
    check("col mem_addr", mem_addr, 32'd84);
    check("col stall", 32'(stall), 32'd1);
    next_cycle();
    drive(1'b1, 32'h4, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    check("col2 if_gnt", 32'(if_gnt), 32'd1);
    check("col2 mem_addr", mem_addr, 32'h4);
    check("col2 dm_valid", 32'(dm_valid), 32'd0);
    check("col2 stall", 32'(stall), 32'd0);
    exp_if.push_back(32'h0040_0093);
    next_cycle();

    // Load after store
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'd84, 32'd0);
    @(negedge clk);
    check("ld dm_gnt", 32'(dm_gnt), 32'd1);
    check("ld mem_we", 32'(mem_we), 32'd0);
    exp_dm.push_back(32'd7);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    check("ld dm_valid", 32'(dm_valid), 32'd1);
    next_cycle();

    // Starvation: four data grants, then the fetch is forced through
    drive(1'b1, 32'h8, 1'b1, 1'b0, 32'd84, 32'd0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check($sformatf("starve%0d dm_gnt", c), 32'(dm_gnt), 32'd1);
      check($sformatf("starve%0d if_gnt", c), 32'(if_gnt), 32'd0);
      exp_dm.push_back(32'd7);
      next_cycle();
    end
    @(negedge clk);
    check("starve5 if_gnt", 32'(if_gnt), 32'd1);
    check("starve5 dm_gnt", 32'(dm_gnt), 32'd0);
    check("starve5 stall", 32'(stall), 32'd1);
    exp_if.push_back(32'h0010_8113);
    next_cycle();
    drive(1'b1, 32'hC, 1'b1, 1'b0, 32'd84, 32'd0);
    @(negedge clk);
    check("starve6 dm_gnt", 32'(dm_gnt), 32'd1);
    check("starve6 if_gnt", 32'(if_gnt), 32'd0);
    exp_dm.push_back(32'd7);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0);
    next_cycle();

    // Back-to-back fetches at 0, 4, 8
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'(k * 4), 1'b0, 1'b0, 32'd0, 32'd0);
      @(negedge clk);
      check($sformatf("b2b%0d if_gnt", k), 32'(if_gnt), 32'd1);
      check($sformatf("b2b%0d stall", k), 32'(stall), 32'd0);
      if (k > 0)
        check($sformatf("b2b%0d if_valid", k), 32'(if_valid), 32'd1);
      exp_if.push_back(mem[k]);
      next_cycle();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    check("b2b3 if_valid", 32'(if_valid), 32'd1);
    next_cycle();

    // Reset while a data read is outstanding
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'd84, 32'd0);
    @(negedge clk);
    check("rr dm_gnt", 32'(dm_gnt), 32'd1);
    next_cycle();
    rst = 1'b1;
    drive(1'b1, 32'h4, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    check("rr dm_valid", 32'(dm_valid), 32'd0);
    check("rr dm_rdata", dm_rdata, 32'h0);
    check("rr if_rdata", if_rdata, 32'h0);
    check("rr if_gnt", 32'(if_gnt), 32'd0);
    check("rr mem_en", 32'(mem_en), 32'd0);
    next_cycle();
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    check("rr post dm_valid", 32'(dm_valid), 32'd0);
    check("rr post if_valid", 32'(if_valid), 32'd0);
    next_cycle();
    drive(1'b1, 32'h4, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    check("rr fetch if_gnt", 32'(if_gnt), 32'd1);
    exp_if.push_back(32'h0040_0093);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0);
    next_cycle();
    next_cycle();

    check("if queue drained", 32'(exp_if.size()), 32'd0);
    check("dm queue drained", 32'(exp_dm.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mem_arbiter
